// File: rtl/dm_responder.sv
// Memory-side load/store responder with configurable wait states and byte-lane merging.
// Optional store trace is enabled by defining DM_TRACE_EN.
module dm_responder #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned LATENCY    = 2,
  parameter logic [31:0] BASE       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned WORDS = 2 ** DEPTH_LOG2;
  localparam int unsigned TAG_W = 30 - DEPTH_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [29:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] mem_q [WORDS];

  logic [DEPTH_LOG2-1:0] word_c;
  logic                  in_range_c;
  logic [31:0]           merged_c;
  logic                  mem_wr_c;

  assign word_c     = addr_q[DEPTH_LOG2-1:0];
  assign in_range_c = (addr_q[29 -: TAG_W] == BASE[31 -: TAG_W]);

  // Lane merge of latched store data over the currently stored word
  always_comb begin
    merged_c = mem_q[word_c];
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) merged_c[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    mem_wr_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr[31:2];
          be_d    = req_be;
          wdata_d = req_wdata;
          cnt_d   = 4'(LATENCY);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Commit cycle: the access happens at this edge
          state_d = ST_RESP;
          if (!in_range_c) begin
            rdata_d = 32'h0;
            err_d   = 1'b1;
          end else if (we_q) begin
            mem_wr_c = |be_q;
            rdata_d  = 32'h0;
            err_d    = 1'b0;
          end else begin
            rdata_d = mem_q[word_c];
            err_d   = 1'b0;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 30'h0;
      be_q        <= 4'h0;
      wdata_q     <= 32'h0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Storage is cleared by reset so a reset run starts from a known image
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < WORDS; i++) mem_q[i] <= 32'h0;
    end else if (mem_wr_c) begin
      mem_q[word_c] <= merged_c;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

`ifdef DM_TRACE_EN
  logic [31:0] pc_q, pc_d;
  logic        unused_c;

  assign pc_d     = (state_q == ST_IDLE && req_valid) ? req_pc : pc_q;
  assign unused_c = ^req_addr[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= 32'h0;
    else       pc_q <= pc_d;
  end

  always_ff @(posedge clk) begin
    if (!reset && mem_wr_c)
      $display("%d@%h: *%h <= %h", $time, pc_q, {addr_q, 2'b00}, merged_c);
  end
`else
  logic unused_c;
  assign unused_c = ^{req_pc, req_addr[1:0]};
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: three instances at LATENCY 2, 4 and 0.
module tb_dm_responder;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        reset       [NI];
  logic        req_valid   [NI];
  logic        req_ready   [NI];
  logic        req_we      [NI];
  logic [31:0] req_addr    [NI];
  logic [3:0]  req_be      [NI];
  logic [31:0] req_wdata   [NI];
  logic [31:0] req_pc      [NI];
  logic        rsp_valid   [NI];
  logic        rsp_ready   [NI];
  logic [31:0] rsp_rdata   [NI];
  logic        rsp_err     [NI];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dm_responder #(
      .DEPTH_LOG2(12),
      .LATENCY   ((g == 0) ? 2 : (g == 1) ? 4 : 0),
      .BASE      (32'h0000_0000)
    ) u_dut (
      .clk      (clk),
      .reset    (reset[g]),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_we   (req_we[g]),
      .req_addr (req_addr[g]),
      .req_be   (req_be[g]),
      .req_wdata(req_wdata[g]),
      .req_pc   (req_pc[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g])
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_be[d]    = be;
    req_wdata[d] = wd;
    req_pc[d]    = 32'h0000_1000 + addr;
    req_valid[d] = 1'b1;
  endtask

  // Presents a request, waits for the accept edge; returns cycles from accept to rsp_valid
  task automatic accept_and_wait(input int d, output int lat);
    int n;
    n = 0;
    while (!req_ready[d] && n < 100) begin tick(); n++; end
    if (n >= 100) check("accept_timeout", 64'(n), 64'(0));
    tick();
    req_valid[d] = 1'b0;
    n = 0;
    while (!rsp_valid[d] && n < 100) begin tick(); n++; end
    if (n >= 100) check("rsp_timeout", 64'(n), 64'(0));
    lat = n + 1;
  endtask

  task automatic xact(input int d, input logic we, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd,
                      output int lat, output logic [31:0] rd, output logic er);
    drive(d, we, addr, be, wd);
    accept_and_wait(d, lat);
    rd = rsp_rdata[d];
    er = rsp_err[d];
    rsp_ready[d] = 1'b1;
    tick();
    rsp_ready[d] = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    int          acc [3];
    logic [31:0] exp6 [3];
    logic [31:0] adr6 [3];

    for (int d = 0; d < NI; d++) begin
      reset[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_be[d] = '0; req_wdata[d] = '0; req_pc[d] = '0; rsp_ready[d] = 1'b0;
    end
    tick(); tick();
    for (int d = 0; d < NI; d++) reset[d] = 1'b0;
    tick();

    // Reset state
    check("rst_ready", 64'(req_ready[0]), 64'(1));
    check("rst_valid", 64'(rsp_valid[0]), 64'(0));
    check("rst_rdata", 64'(rsp_rdata[0]), 64'(0));
    check("rst_err",   64'(rsp_err[0]),   64'(0));

    // 1: full-word store then load
    xact(0, 1'b1, 32'h10, 4'b1111, 32'hDEAD_BEEF, lat, rd, er);
    check("st1_lat", 64'(lat), 64'(4));
    check("st1_err", 64'(er), 64'(0));
    check("st1_rdata", 64'(rd), 64'(0));
    xact(0, 1'b0, 32'h10, 4'b0000, 32'h0, lat, rd, er);
    check("ld1_lat", 64'(lat), 64'(4));
    check("ld1_rdata", 64'(rd), 64'hDEAD_BEEF);
    check("ld1_err", 64'(er), 64'(0));

    // 2: single-lane merge
    xact(0, 1'b1, 32'h12, 4'b0010, 32'h0000_AB00, lat, rd, er);
    check("st2_err", 64'(er), 64'(0));
    xact(0, 1'b0, 32'h10, 4'b0000, 32'h0, lat, rd, er);
    check("ld2_rdata", 64'(rd), 64'hDEAD_ABEF);

    // be=0 store is a committed no-op
    xact(0, 1'b1, 32'h10, 4'b0000, 32'h1111_1111, lat, rd, er);
    check("nop_err", 64'(er), 64'(0));
    xact(0, 1'b0, 32'h10, 4'b0000, 32'h0, lat, rd, er);
    check("nop_rdata", 64'(rd), 64'hDEAD_ABEF);

    // 3: out-of-range store
    xact(0, 1'b1, 32'h0000_4000, 4'b1111, 32'h1234_5678, lat, rd, er);
    check("oor_err", 64'(er), 64'(1));
    check("oor_rdata", 64'(rd), 64'(0));
    xact(0, 1'b0, 32'h0, 4'b0000, 32'h0, lat, rd, er);
    check("oor_ld_rdata", 64'(rd), 64'(0));
    check("oor_ld_err", 64'(er), 64'(0));

    // 4: response backpressure with a second request waiting
    drive(0, 1'b0, 32'h10, 4'b0000, 32'h0);
    accept_and_wait(0, lat);
    check("bp_lat", 64'(lat), 64'(4));
    drive(0, 1'b0, 32'h0, 4'b0000, 32'h0);
    for (int k = 0; k < 5; k++) begin
      check("bp_hold", {29'h0, rsp_valid[0], req_ready[0], rsp_err[0], rsp_rdata[0]},
            {29'h0, 1'b1, 1'b0, 1'b0, 32'hDEAD_ABEF});
      tick();
    end
    rsp_ready[0] = 1'b1;
    tick();
    rsp_ready[0] = 1'b0;
    check("bp_idle_ready", 64'(req_ready[0]), 64'(1));
    check("bp_idle_valid", 64'(rsp_valid[0]), 64'(0));
    tick();
    req_valid[0] = 1'b0;
    check("bp_accepted", 64'(req_ready[0]), 64'(0));
    lat = 0;
    while (!rsp_valid[0] && lat < 100) begin tick(); lat++; end
    check("bp2_lat", 64'(lat + 1), 64'(4));
    check("bp2_rdata", 64'(rsp_rdata[0]), 64'(0));
    rsp_ready[0] = 1'b1;
    tick();
    rsp_ready[0] = 1'b0;

    // 5: reset during WAIT (LATENCY=4) discards the store and clears memory
    xact(1, 1'b1, 32'h24, 4'b1111, 32'h5555_AAAA, lat, rd, er);
    check("l4_lat", 64'(lat), 64'(6));
    xact(1, 1'b1, 32'h20, 4'b1111, 32'h0BAD_0BAD, lat, rd, er);
    drive(1, 1'b0, 32'h0, 4'b0000, 32'h0);
    xact(1, 1'b0, 32'h20, 4'b0000, 32'h0, lat, rd, er);
    check("l4_pre_rdata", 64'(rd), 64'h0BAD_0BAD);
    drive(1, 1'b1, 32'h20, 4'b1111, 32'hCAFE_F00D);
    tick();
    req_valid[1] = 1'b0;
    check("l4_wait", 64'(req_ready[1]), 64'(0));
    tick(); tick();
    #2;
    reset[1] = 1'b1;
    #1;
    check("rst_imm_valid", 64'(rsp_valid[1]), 64'(0));
    check("rst_imm_ready", 64'(req_ready[1]), 64'(1));
    tick(); tick();
    reset[1] = 1'b0;
    tick();
    xact(1, 1'b0, 32'h20, 4'b0000, 32'h0, lat, rd, er);
    check("rst_ld20", 64'(rd), 64'(0));
    xact(1, 1'b0, 32'h24, 4'b0000, 32'h0, lat, rd, er);
    check("rst_ld24", 64'(rd), 64'(0));

    // 6: LATENCY=0 back-to-back loads with rsp_ready held high
    xact(2, 1'b1, 32'h8, 4'b1111, 32'h1122_3344, lat, rd, er);
    check("l0_st_lat", 64'(lat), 64'(2));
    adr6[0] = 32'h8; adr6[1] = 32'h0; adr6[2] = 32'h8;
    exp6[0] = 32'h1122_3344; exp6[1] = 32'h0; exp6[2] = 32'h1122_3344;
    rsp_ready[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(2, 1'b0, adr6[k], 4'b0000, 32'h0);
      lat = 0;
      while (!req_ready[2] && lat < 100) begin tick(); lat++; end
      acc[k] = cyc;
      tick();
      lat = 0;
      while (!rsp_valid[2] && lat < 100) begin tick(); lat++; end
      check("b2b_lat", 64'(lat + 1), 64'(2));
      check("b2b_rdata", 64'(rsp_rdata[2]), 64'(exp6[k]));
      tick();
      if (k > 0) check("b2b_period", 64'(acc[k] - acc[k-1]), 64'(3));
    end
    req_valid[2] = 1'b0;
    rsp_ready[2] = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
